// File: rtl/post_mac_pkg.sv
// Shared types and helpers for the post-MAC pipeline: beat modes, ReLU floor
// and a generic signed saturator used by both the lane and reduction paths.
package post_mac_pkg;

    typedef enum logic [1:0] {
        MODE_CONV_CH  = 2'b00,
        MODE_CONV_RED = 2'b01,
        MODE_FC       = 2'b10,
        MODE_OFF      = 2'b11
    } mode_e;

    localparam int SAT_W     = 64;
    localparam int RELU_ZERO = 0;

    // Clamp v into the signed range of a w-bit number; caller narrows the result.
    function automatic logic signed [SAT_W-1:0] saturate(
        input logic signed [SAT_W-1:0] v,
        input int unsigned             w
    );
        logic signed [SAT_W-1:0] hi;
        logic signed [SAT_W-1:0] lo;
        hi = (64'sd1 <<< (w - 1)) - 64'sd1;
        lo = -(64'sd1 <<< (w - 1));
        if (v > hi) begin
            return hi;
        end else if (v < lo) begin
            return lo;
        end
        return v;
    endfunction

endpackage

// File: rtl/post_mac_lane.sv
// One accumulator lane: S1 bias add (or pass-through), S2 ReLU, floor shift
// and saturation. Advances only when the shared pipeline enable is high.
module post_mac_lane
    import post_mac_pkg::*;
#(
    parameter int ACC_W      = 32,
    parameter int OUT_W      = 16,
    parameter int FRAC_SHIFT = 4
) (
    input  logic                    clk,
    input  logic                    reset_n,
    input  logic                    i_en,
    input  mode_e                   i_mode_p0,
    input  logic signed [ACC_W-1:0] i_acc,
    input  logic signed [ACC_W-1:0] i_bias,
    input  mode_e                   i_mode_p1,
    output logic signed [OUT_W-1:0] o_data_p2
);

    logic signed [ACC_W:0]   w_val_p0;
    logic signed [ACC_W:0]   r_val_p1;
    logic signed [ACC_W:0]   w_relu_p1;
    logic signed [ACC_W:0]   w_shr_p1;
    logic signed [OUT_W-1:0] w_res_p1;

    always_comb begin
        case (i_mode_p0)
            MODE_CONV_CH: w_val_p0 = {i_acc[ACC_W-1], i_acc} + {i_bias[ACC_W-1], i_bias};
            MODE_FC:      w_val_p0 = {i_acc[ACC_W-1], i_acc};
            default:      w_val_p0 = '0;
        endcase
    end

    // S1 boundary
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_val_p1 <= '0;
        end else if (i_en) begin
            r_val_p1 <= w_val_p0;
        end
    end

    always_comb begin
        w_relu_p1 = r_val_p1;
        if (i_mode_p1 == MODE_CONV_CH && r_val_p1[ACC_W]) begin
            w_relu_p1 = (ACC_W + 1)'(RELU_ZERO);
        end
        w_shr_p1 = w_relu_p1 >>> FRAC_SHIFT;
        w_res_p1 = '0;
        if (i_mode_p1 == MODE_CONV_CH || i_mode_p1 == MODE_FC) begin
            w_res_p1 = OUT_W'(saturate(SAT_W'(w_shr_p1), OUT_W));
        end
    end

    // S2 boundary
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            o_data_p2 <= '0;
        end else if (i_en) begin
            o_data_p2 <= w_res_p1;
        end
    end

endmodule

// File: rtl/post_mac_pipe.sv
// Two-stage post-MAC unit with valid/ready flow control, loadable biases,
// a cross-lane reduction path and a frame-level argmax for the FC layer.
module post_mac_pipe
    import post_mac_pkg::*;
#(
    parameter int N_CH       = 6,
    parameter int ACC_W      = 32,
    parameter int OUT_W      = 16,
    parameter int FRAC_SHIFT = 4,
    parameter int IDX_W      = 8
) (
    input  logic                         clk,
    input  logic                         reset_n,
    input  logic                         in_valid,
    output logic                         in_ready,
    input  logic [1:0]                   in_mode,
    input  logic                         in_last,
    input  logic [N_CH*ACC_W-1:0]        in_acc,
    input  logic                         bias_we,
    input  logic [$clog2(N_CH+1)-1:0]    bias_addr,
    input  logic signed [ACC_W-1:0]      bias_wdata,
    output logic                         out_valid,
    input  logic                         out_ready,
    output logic [N_CH*OUT_W-1:0]        out_data,
    output logic signed [OUT_W-1:0]      out_red,
    output logic [1:0]                   out_mode,
    output logic                         argmax_valid,
    output logic [IDX_W-1:0]             argmax_idx
);

    localparam int BA_W  = $clog2(N_CH + 1);
    localparam int RED_W = ACC_W + $clog2(N_CH + 1);

    logic                    w_adv;
    logic                    w_hs;
    mode_e                   w_mode_p0;
    logic signed [ACC_W-1:0] r_bias [N_CH+1];

    logic                    r_vld_p1;
    logic                    r_last_p1;
    mode_e                   r_mode_p1;
    logic                    r_vld_p2;
    logic                    r_last_p2;
    mode_e                   r_mode_p2;

    logic signed [RED_W-1:0] w_red_p0;
    logic signed [RED_W-1:0] r_red_p1;
    logic signed [RED_W-1:0] w_red_relu_p1;
    logic signed [RED_W-1:0] w_red_shr_p1;
    logic signed [OUT_W-1:0] w_red_res_p1;
    logic signed [OUT_W-1:0] r_red_p2;

    logic signed [OUT_W-1:0] w_lane_p2 [N_CH];

    logic [IDX_W-1:0]        r_beat_cnt;
    logic signed [OUT_W-1:0] r_max;
    logic [IDX_W-1:0]        r_idx;
    logic signed [OUT_W-1:0] w_max_p2;
    logic [IDX_W-1:0]        w_idx_p2;
    logic [IDX_W-1:0]        w_g_p2;
    logic                    r_argmax_valid;
    logic [IDX_W-1:0]        r_argmax_idx;

    // The whole pipe moves together; a full output slot blocks everything.
    assign w_adv     = !r_vld_p2 || out_ready;
    assign w_hs      = r_vld_p2 && out_ready;
    assign w_mode_p0 = mode_e'(in_mode);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i <= N_CH; i++) begin
                r_bias[i] <= '0;
            end
        end else if (bias_we && bias_addr <= BA_W'(N_CH)) begin
            r_bias[bias_addr] <= bias_wdata;
        end
    end

    always_comb begin
        w_red_p0 = {{(RED_W - ACC_W){r_bias[N_CH][ACC_W-1]}}, r_bias[N_CH]};
        for (int c = 0; c < N_CH; c++) begin
            w_red_p0 = w_red_p0 + {{(RED_W - ACC_W){in_acc[c*ACC_W + ACC_W - 1]}},
                                   in_acc[c*ACC_W +: ACC_W]};
        end
    end

    // S1 boundary
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_vld_p1  <= 1'b0;
            r_last_p1 <= 1'b0;
            r_mode_p1 <= MODE_CONV_CH;
            r_red_p1  <= '0;
        end else if (w_adv) begin
            r_vld_p1  <= in_valid;
            r_last_p1 <= in_last;
            r_mode_p1 <= w_mode_p0;
            r_red_p1  <= w_red_p0;
        end
    end

    always_comb begin
        w_red_relu_p1 = r_red_p1[RED_W-1] ? RED_W'(RELU_ZERO) : r_red_p1;
        w_red_shr_p1  = w_red_relu_p1 >>> FRAC_SHIFT;
        w_red_res_p1  = '0;
        if (r_mode_p1 == MODE_CONV_RED) begin
            w_red_res_p1 = OUT_W'(saturate(SAT_W'(w_red_shr_p1), OUT_W));
        end
    end

    // S2 boundary
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_vld_p2  <= 1'b0;
            r_last_p2 <= 1'b0;
            r_mode_p2 <= MODE_CONV_CH;
            r_red_p2  <= '0;
        end else if (w_adv) begin
            r_vld_p2  <= r_vld_p1;
            r_last_p2 <= r_last_p1;
            r_mode_p2 <= r_mode_p1;
            r_red_p2  <= w_red_res_p1;
        end
    end

    for (genvar c = 0; c < N_CH; c++) begin : g_lane
        post_mac_lane #(
            .ACC_W      (ACC_W),
            .OUT_W      (OUT_W),
            .FRAC_SHIFT (FRAC_SHIFT)
        ) u_lane (
            .clk       (clk),
            .reset_n   (reset_n),
            .i_en      (w_adv),
            .i_mode_p0 (w_mode_p0),
            .i_acc     (in_acc[c*ACC_W +: ACC_W]),
            .i_bias    (r_bias[c]),
            .i_mode_p1 (r_mode_p1),
            .o_data_p2 (w_lane_p2[c])
        );
        assign out_data[c*OUT_W +: OUT_W] = w_lane_p2[c];
    end

    // Scan the presented beat; strict '>' keeps the lowest index on ties.
    always_comb begin
        w_max_p2 = r_max;
        w_idx_p2 = r_idx;
        w_g_p2   = '0;
        for (int c = 0; c < N_CH; c++) begin
            w_g_p2 = r_beat_cnt * IDX_W'(N_CH) + IDX_W'(c);
            if ((r_beat_cnt == '0 && c == 0) || (w_lane_p2[c] > w_max_p2)) begin
                w_max_p2 = w_lane_p2[c];
                w_idx_p2 = w_g_p2;
            end
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_beat_cnt     <= '0;
            r_max          <= '0;
            r_idx          <= '0;
            r_argmax_valid <= 1'b0;
            r_argmax_idx   <= '0;
        end else begin
            r_argmax_valid <= 1'b0;
            if (w_hs && r_mode_p2 == MODE_FC) begin
                if (r_last_p2) begin
                    r_argmax_valid <= 1'b1;
                    r_argmax_idx   <= w_idx_p2;
                    r_beat_cnt     <= '0;
                    r_max          <= '0;
                    r_idx          <= '0;
                end else begin
                    r_beat_cnt <= r_beat_cnt + 1'b1;
                    r_max      <= w_max_p2;
                    r_idx      <= w_idx_p2;
                end
            end
        end
    end

    assign in_ready     = w_adv;
    assign out_valid    = r_vld_p2;
    assign out_red      = r_red_p2;
    assign out_mode     = r_mode_p2;
    assign argmax_valid = r_argmax_valid;
    assign argmax_idx   = r_argmax_idx;

endmodule

// File: tb/tb_post_mac_pipe.sv
// Directed bench for post_mac_pipe: hand-computed results for each mode,
// saturation, ReLU, bias timing, backpressure, reset and FC argmax.
module tb_post_mac_pipe;

    localparam int N  = 6;
    localparam int AW = 32;
    localparam int OW = 16;
    localparam int IW = 8;
    localparam int BW = 3;

    logic                 clk = 1'b0;
    logic                 reset_n = 1'b0;
    logic                 in_valid = 1'b0;
    logic                 in_ready;
    logic [1:0]           in_mode = 2'b00;
    logic                 in_last = 1'b0;
    logic [N*AW-1:0]      in_acc = '0;
    logic                 bias_we = 1'b0;
    logic [BW-1:0]        bias_addr = '0;
    logic signed [AW-1:0] bias_wdata = '0;
    logic                 out_valid;
    logic                 out_ready;
    logic [N*OW-1:0]      out_data;
    logic signed [OW-1:0] out_red;
    logic [1:0]           out_mode;
    logic                 argmax_valid;
    logic [IW-1:0]        argmax_idx;

    logic                 rdy_main = 1'b1;
    logic                 rdy_bp = 1'b1;
    logic                 bp_en = 1'b0;
    assign out_ready = bp_en ? rdy_bp : rdy_main;

    int n_err = 0;
    int n_chk = 0;

    typedef struct {
        logic [1:0]           m;
        logic signed [OW-1:0] r;
        logic [N*OW-1:0]      d;
    } obs_t;
    obs_t q[$];

    int            pulses = 0;
    logic [IW-1:0] last_idx = '0;

    post_mac_pipe #(
        .N_CH(N), .ACC_W(AW), .OUT_W(OW), .FRAC_SHIFT(4), .IDX_W(IW)
    ) dut (
        .clk          (clk),
        .reset_n      (reset_n),
        .in_valid     (in_valid),
        .in_ready     (in_ready),
        .in_mode      (in_mode),
        .in_last      (in_last),
        .in_acc       (in_acc),
        .bias_we      (bias_we),
        .bias_addr    (bias_addr),
        .bias_wdata   (bias_wdata),
        .out_valid    (out_valid),
        .out_ready    (out_ready),
        .out_data     (out_data),
        .out_red      (out_red),
        .out_mode     (out_mode),
        .argmax_valid (argmax_valid),
        .argmax_idx   (argmax_idx)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input longint got, input longint exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
        end
    endtask

    function automatic logic signed [OW-1:0] lane_of(input logic [N*OW-1:0] d, input int c);
        return d[c*OW +: OW];
    endfunction

    function automatic logic [N*AW-1:0] pk(
        input logic signed [AW-1:0] v0, input logic signed [AW-1:0] v1,
        input logic signed [AW-1:0] v2, input logic signed [AW-1:0] v3,
        input logic signed [AW-1:0] v4, input logic signed [AW-1:0] v5);
        return {v5, v4, v3, v2, v1, v0};
    endfunction

    // Out-ready pattern 1,0,0,1 repeating, used while bp_en is set.
    int k_bp = 0;
    logic [3:0] bp_pat = 4'b1001;
    always @(posedge clk) begin
        #1;
        rdy_bp = bp_pat[k_bp % 4];
        k_bp++;
    end

    // Output monitor: captures handshakes, argmax pulses and stall stability.
    logic                 stall_prev = 1'b0;
    logic [N*OW-1:0]      snap_d;
    logic signed [OW-1:0] snap_r;
    logic [1:0]           snap_m;
    always @(negedge clk) begin
        obs_t o;
        if (reset_n) begin
            if (stall_prev) begin
                chk("stall_hold", longint'(out_valid && out_data === snap_d &&
                                           out_red === snap_r && out_mode === snap_m), 1);
            end
            if (out_valid && out_ready) begin
                o.m = out_mode;
                o.r = out_red;
                o.d = out_data;
                q.push_back(o);
            end
            if (argmax_valid) begin
                pulses++;
                last_idx = argmax_idx;
            end
            stall_prev = out_valid && !out_ready;
            snap_d = out_data;
            snap_r = out_red;
            snap_m = out_mode;
        end else begin
            stall_prev = 1'b0;
        end
    end

    task automatic send(input logic [1:0] m, input logic l, input logic [N*AW-1:0] a);
        int t;
        t = 0;
        in_valid = 1'b1;
        in_mode  = m;
        in_last  = l;
        in_acc   = a;
        @(negedge clk);
        while (!in_ready && t < 50) begin
            @(negedge clk);
            t++;
        end
        if (!in_ready) chk("accept_timeout", 0, 1);
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        in_last  = 1'b0;
    endtask

    task automatic wr_bias(input logic [BW-1:0] addr, input logic signed [AW-1:0] val);
        bias_we    = 1'b1;
        bias_addr  = addr;
        bias_wdata = val;
        @(posedge clk);
        #1;
        bias_we = 1'b0;
    endtask

    task automatic wait_obs(input int n);
        int t;
        t = 0;
        while (q.size() < n && t < 200) begin
            @(posedge clk);
            #1;
            t++;
        end
        chk("out_count", q.size(), n);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish, checks=%0d", n_chk);
        $fatal(1, "watchdog");
    end

    initial begin
        repeat (2) @(posedge clk);
        #1;
        chk("rst_out_valid", out_valid, 0);
        chk("rst_out_data_zero", longint'(out_data == '0), 1);
        chk("rst_out_red", out_red, 0);
        chk("rst_argmax_valid", argmax_valid, 0);
        chk("rst_argmax_idx", argmax_idx, 0);
        chk("rst_in_ready", in_ready, 1);
        reset_n = 1'b1;
        @(posedge clk);
        #1;

        // Reset while two beats are in flight
        send(2'b10, 1'b0, pk(160, 0, 0, 0, 0, 0));
        send(2'b10, 1'b0, pk(320, 0, 0, 0, 0, 0));
        chk("pre_rst_valid", out_valid, 1);
        chk("pre_rst_lane0", lane_of(out_data, 0), 10);
        reset_n = 1'b0;
        #1;
        chk("mid_rst_valid", out_valid, 0);
        chk("mid_rst_data_zero", longint'(out_data == '0), 1);
        repeat (2) @(posedge clk);
        #1;
        q.delete();
        reset_n = 1'b1;
        repeat (5) @(posedge clk);
        #1;
        chk("no_stale_beat", q.size(), 0);

        // Mode 00: bias, ReLU, saturation, latency
        wr_bias(3'd0, -188);
        wr_bias(3'd1, -224);
        send(2'b00, 1'b0, pk(1000, 100, 32'h7FFF_FFFF, 0, 0, 0));
        chk("lat_s1_not_valid", out_valid, 0);
        @(posedge clk);
        #1;
        chk("lat_s2_valid", out_valid, 1);
        wait_obs(1);
        chk("m00_lane0_bias", lane_of(q[0].d, 0), 50);
        chk("m00_lane1_relu", lane_of(q[0].d, 1), 0);
        chk("m00_lane2_sat", lane_of(q[0].d, 2), 32767);
        chk("m00_lane5", lane_of(q[0].d, 5), 0);
        chk("m00_red_zero", q[0].r, 0);
        chk("m00_mode", q[0].m, 0);
        q.delete();

        // Mode 01: reduction saturation, ReLU, reduction bias, bad address
        send(2'b01, 1'b0, pk(32'h4000_0000, 32'h4000_0000, 32'h4000_0000,
                             32'h4000_0000, 32'h4000_0000, 32'h4000_0000));
        send(2'b01, 1'b0, pk(-16, -16, -16, -16, -16, -16));
        wr_bias(3'd6, 160);
        wr_bias(3'd7, 5000);
        send(2'b01, 1'b0, pk(16, 16, 16, 16, 16, 16));
        wait_obs(3);
        chk("m01_red_sat", q[0].r, 32767);
        chk("m01_red_relu", q[1].r, 0);
        chk("m01_red_bias", q[2].r, 16);
        chk("m01_lane_zero", longint'(q[2].d == '0), 1);
        chk("m01_mode", q[2].m, 1);
        q.delete();

        // Mode 10 single-beat frame and mode 11
        pulses = 0;
        send(2'b10, 1'b1, pk(-17, 32'h8000_0000, 32'h7FFF_FFFF, 15, 16, -1));
        send(2'b11, 1'b0, pk(16000, 16000, 16000, 16000, 16000, 16000));
        wait_obs(2);
        repeat (2) @(posedge clk);
        #1;
        chk("m10_floor_neg", lane_of(q[0].d, 0), -2);
        chk("m10_sat_neg", lane_of(q[0].d, 1), -32768);
        chk("m10_sat_pos", lane_of(q[0].d, 2), 32767);
        chk("m10_small", lane_of(q[0].d, 3), 0);
        chk("m10_one", lane_of(q[0].d, 4), 1);
        chk("m10_minus1", lane_of(q[0].d, 5), -1);
        chk("m10_pulses", pulses, 1);
        chk("m10_argmax", last_idx, 2);
        chk("m11_data_zero", longint'(q[1].d == '0), 1);
        chk("m11_red_zero", q[1].r, 0);
        chk("m11_mode", q[1].m, 3);
        q.delete();

        // Bias write colliding with an accept
        wr_bias(3'd0, 0);
        bias_we    = 1'b1;
        bias_addr  = 3'd0;
        bias_wdata = 16;
        send(2'b00, 1'b0, pk(0, 0, 0, 0, 0, 0));
        bias_we = 1'b0;
        send(2'b00, 1'b0, pk(0, 0, 0, 0, 0, 0));
        wait_obs(2);
        chk("bias_old_value", lane_of(q[0].d, 0), 0);
        chk("bias_new_value", lane_of(q[1].d, 0), 1);
        q.delete();

        // Backpressure stream, also an 8-beat FC frame with a tie
        pulses = 0;
        bp_en  = 1'b1;
        for (int k = 0; k < 8; k++) begin
            send(2'b10, (k == 7), pk((k + 1) * 16, 0, 0, 7 * 16, 0, 0));
        end
        wait_obs(8);
        bp_en = 1'b0;
        repeat (4) @(posedge clk);
        #1;
        chk("bp_no_dup", q.size(), 8);
        for (int k = 0; k < 8; k++) begin
            chk($sformatf("bp_order_%0d", k), lane_of(q[k].d, 0), k + 1);
            chk($sformatf("bp_lane3_%0d", k), lane_of(q[k].d, 3), 7);
        end
        chk("bp_pulses", pulses, 1);
        chk("bp_argmax", last_idx, 42);
        q.delete();

        // FC frame with an interleaved conv beat
        pulses = 0;
        send(2'b10, 1'b0, pk(5 * 16, 9 * 16, 3 * 16, 9 * 16, 0, 0));
        send(2'b00, 1'b0, pk(16000, 16000, 16000, 16000, 16000, 16000));
        send(2'b10, 1'b1, pk(1 * 16, 2 * 16, 20 * 16, 0, 0, 20 * 16));
        wait_obs(3);
        repeat (3) @(posedge clk);
        #1;
        chk("fc_conv_beat", lane_of(q[1].d, 0), 1001);
        chk("fc_beat1_lane2", lane_of(q[2].d, 2), 20);
        chk("fc_pulses", pulses, 1);
        chk("fc_argmax", last_idx, 8);
        repeat (3) @(posedge clk);
        #1;
        chk("fc_idx_hold", argmax_idx, 8);
        chk("fc_pulse_low", argmax_valid, 0);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
